axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameter ADDR_WTH, default 32, AXI address width.
REQ-002 Parameter DATA_WTH, default 256, AXI data width (bits, power of two, >=64).
REQ-003 Parameter ID_WIDTH, default 4, AXI ID width.
REQ-004 Parameter AXI_ID, default 0, constant ID driven on awid/arid.
REQ-005 clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 req_valid/req_ready  in/out  1/1  command handshake.
REQ-008 req_we  in  1  1 = write burst, 0 = read burst.
REQ-009 req_addr  in  ADDR_WTH  byte address, DATA_WTH/8-aligned.
REQ-010 req_len  in  8  beats minus one (AXI len encoding).
REQ-011 wd_valid/wd_ready, wd_data, wd_strb  in/out, in, in  1/1, DATA_WTH, DATA_WTH/8  write-data stream.
REQ-012 rd_valid/rd_ready, rd_data, rd_last  out/in, out, out  1/1, DATA_WTH, 1  read-data stream.
REQ-013 done_valid, done_err  out, out  1, 1  one-cycle completion pulse; err = nonzero resp or rejected command.
REQ-014 AXI AW: awaddr, awlen, awsize, awburst, awid, awvalid out; awready in; awcache/awlock/awprot/awqos/awregion out, tied 0.
REQ-015 AXI W: wdata, wstrb, wlast, wvalid out; wready in.
REQ-016 AXI B: bresp, bid, bvalid in; bready out.
REQ-017 AXI AR: araddr, arlen, arsize, arburst, arid, arvalid out; arready in; arcache/arlock/arprot/arqos/arregion out, tied 0.
REQ-018 AXI R: rdata, rresp, rid, rlast, rvalid in; rready out.

Function
REQ-019 States: IDLE, AR, R, AW, W, B; exactly one transaction outstanding.
REQ-020 IDLE: req_ready=1; on req_valid latch addr/len/we; go AR (read) or AW (write).
REQ-021 Commands whose burst crosses a 4 KiB boundary (addr[11:0] + (len+1)*DATA_WTH/8 > 4096) or are misaligned: no AXI traffic, done_valid=1 with done_err=1 next cycle, stay IDLE.
REQ-022 awsize/arsize = log2(DATA_WTH/8); awburst/arburst = 2'b01 (INCR); id = AXI_ID.
REQ-023 AR/AW: valid held high, address/len stable until ready; AR->R, AW->W on handshake.
REQ-024 R: rready = rd_ready, rd_valid = rvalid, rd_data/rd_last pass-through (zero added latency); beat counter 8 bits.
REQ-025 R exit on rvalid&rready&rlast: done_valid=1, done_err = OR of (rresp!=0) over burst, OR of rid!=AXI_ID; -> IDLE.
REQ-026 rlast at beat count != len, or beat count reaching len+1 without rlast: done_err=1, transaction ends at the rlast beat.
REQ-027 W: wvalid = wd_valid, wd_ready = wready, wdata/wstrb pass-through; wlast asserted exactly when beat count == len.
REQ-028 W exit on last beat handshake -> B; bready=1 only in B.
REQ-029 B: on bvalid: done_valid=1, done_err = (bresp!=0) | (bid!=AXI_ID); -> IDLE.
REQ-030 AW and W are sequential: wvalid never asserted before awvalid&awready.
REQ-031 Back-to-back: req_ready reasserts the cycle after done_valid; no idle cycle beyond that.
REQ-032 len=0: single beat with wlast/rlast on beat 0.

Reset
REQ-033 Asynchronous assertion; all valid outputs (awvalid, wvalid, arvalid, bready, rready, rd_valid, done_valid) 0, state IDLE, counters 0, req_ready 1 after release.
REQ-034 Reset mid-burst abandons the transaction without completion pulse; no further AXI signalling until a new request.

Structure
REQ-035 Shared package axi_mst_pkg: state enum, AXI burst/resp constants, size-encode function.
REQ-036 Single module; no sub-module.

Verification
REQ-037 Read addr 0x80000000, len=3, slave ready 1-in-4 cycles -> 4 beats in order, rd_last on beat 3, done_err=0.
REQ-038 Write addr 0x80000100, len=7, wstrb=all-ones -> awlen=7, wlast only on beat 7, one done pulse after bvalid.
REQ-039 Read addr 0x80000FE0, len=1 with DATA_WTH=256 -> rejected, no arvalid, done_err=1.
REQ-040 Slave returns bresp=2'b10 -> done_err=1; next request accepted the following cycle.
REQ-041 rst_i asserted during W beat 2 of len=5 -> wvalid drops immediately, no done_valid, clean read afterward.
REQ-042 wd_valid gaps with wready constant 1 -> wvalid follows wd_valid, beat count unaffected by gaps.

Source files
------------

// File: rtl/axi_mst_pkg.sv
// Shared definitions for the AXI burst master.
//   mst_state_e      : FSM encoding (one transaction outstanding at a time)
//   AXI_BURST_INCR   : burst type driven on awburst/arburst
//   AXI_RESP_*       : response codes; anything other than OKAY is an error
//   axi_size_enc()   : log2(bytes per beat) for awsize/arsize
package axi_mst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } mst_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Bytes-per-beat encoding; data_wth is a power of two of at least 64.
    function automatic logic [2:0] axi_size_enc(input int unsigned data_wth);
        logic [2:0] enc;
        enc = '0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == data_wth / 8) enc = 3'(i);
        end
        return enc;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master.
// A command (req_*) starts one INCR burst: read (AR then R) or write (AW then W then B).
// Read data leaves on rd_*, write data arrives on wd_*; both streams pass straight
// through to the R/W channels with no added latency. Each accepted command ends with
// a one-cycle done_valid pulse; done_err flags a bad response, an unexpected ID, a
// mis-framed read burst, or a command refused for misalignment / 4 KiB crossing.
// dbg_state exposes the FSM state.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a rising edge
// where both are high; once valid is raised by this block its payload stays stable
// until that transfer.
module axi_burst_master
    import axi_mst_pkg::*;
#(
    parameter int                    ADDR_WTH = 32,
    parameter int                    DATA_WTH = 256,
    parameter int                    ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0]   AXI_ID   = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // command
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WTH-1:0]       req_addr,
    input  logic [7:0]                req_len,
    // write-data stream
    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [DATA_WTH-1:0]       wd_data,
    input  logic [DATA_WTH/8-1:0]     wd_strb,
    // read-data stream
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_WTH-1:0]       rd_data,
    output logic                      rd_last,
    // completion
    output logic                      done_valid,
    output logic                      done_err,
    // AXI AW
    output logic [ADDR_WTH-1:0]       awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [ID_WIDTH-1:0]       awid,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [3:0]                awcache,
    output logic                      awlock,
    output logic [2:0]                awprot,
    output logic [3:0]                awqos,
    output logic [3:0]                awregion,
    // AXI W
    output logic [DATA_WTH-1:0]       wdata,
    output logic [DATA_WTH/8-1:0]     wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    // AXI B
    input  logic [1:0]                bresp,
    input  logic [ID_WIDTH-1:0]       bid,
    input  logic                      bvalid,
    output logic                      bready,
    // AXI AR
    output logic [ADDR_WTH-1:0]       araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [ID_WIDTH-1:0]       arid,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [3:0]                arcache,
    output logic                      arlock,
    output logic [2:0]                arprot,
    output logic [3:0]                arqos,
    output logic [3:0]                arregion,
    // AXI R
    input  logic [DATA_WTH-1:0]       rdata,
    input  logic [1:0]                rresp,
    input  logic [ID_WIDTH-1:0]       rid,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    // debug
    output mst_state_e                dbg_state
);

    localparam logic [2:0]  AXSIZE = axi_size_enc(DATA_WTH);
    localparam int          SIZE   = int'(AXSIZE);
    localparam int unsigned BYTES  = DATA_WTH / 8;

    mst_state_e            state_q, state_d;
    logic [ADDR_WTH-1:0]   addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rej_q, rej_d;

    logic                  rd_beat, wr_beat, rd_done, b_done;
    logic                  beat_err, b_err, cmd_bad;
    logic [31:0]           end_off;

    // Offset of the first byte past the burst within its 4 KiB page.
    assign end_off  = 32'(req_addr[11:0]) + (32'(req_len) + 32'd1) * BYTES;
    assign cmd_bad  = (|req_addr[SIZE-1:0]) || (end_off > 32'd4096);

    assign rd_beat  = (state_q == ST_R) && rvalid && rd_ready;
    assign wr_beat  = (state_q == ST_W) && wd_valid && wready;
    assign rd_done  = rd_beat && rlast;
    assign b_done   = (state_q == ST_B) && bvalid;

    // A beat is mis-framed when rlast disagrees with the expected final beat; this
    // covers both an early rlast and a burst running past len without rlast.
    assign beat_err = (rresp != AXI_RESP_OKAY) || (rid != AXI_ID) ||
                      (rlast != (cnt_q == len_q));
    assign b_err    = (bresp != AXI_RESP_OKAY) || (bid != AXI_ID);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rej_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (cmd_bad) begin
                        rej_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        len_d   = req_len;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = req_we ? ST_AW : ST_AR;
                    end
                end
            end
            ST_AR: if (arready) state_d = ST_R;
            ST_R: begin
                if (rd_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    err_d = err_q | beat_err;
                    if (rlast) state_d = ST_IDLE;
                end
            end
            ST_AW: if (awready) state_d = ST_W;
            ST_W: begin
                if (wr_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == len_q) state_d = ST_B;
                end
            end
            ST_B: if (bvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rej_q   <= rej_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign dbg_state  = state_q;

    // Completion fires in the cycle of the closing handshake so that the next
    // command can be taken on the very next cycle; a refusal reports one cycle later.
    assign done_valid = rej_q || rd_done || b_done;
    assign done_err   = rej_q || (rd_done && (err_q || beat_err)) || (b_done && b_err);

    assign awaddr   = addr_q;
    assign awlen    = len_q;
    assign awsize   = AXSIZE;
    assign awburst  = AXI_BURST_INCR;
    assign awid     = AXI_ID;
    assign awvalid  = (state_q == ST_AW);
    assign awcache  = '0;
    assign awlock   = 1'b0;
    assign awprot   = '0;
    assign awqos    = '0;
    assign awregion = '0;

    // W only opens after the AW handshake has moved the FSM into ST_W.
    assign wdata    = wd_data;
    assign wstrb    = wd_strb;
    assign wvalid   = (state_q == ST_W) && wd_valid;
    assign wd_ready = (state_q == ST_W) && wready;
    assign wlast    = (state_q == ST_W) && (cnt_q == len_q);

    assign bready   = (state_q == ST_B);

    assign araddr   = addr_q;
    assign arlen    = len_q;
    assign arsize   = AXSIZE;
    assign arburst  = AXI_BURST_INCR;
    assign arid     = AXI_ID;
    assign arvalid  = (state_q == ST_AR);
    assign arcache  = '0;
    assign arlock   = 1'b0;
    assign arprot   = '0;
    assign arqos    = '0;
    assign arregion = '0;

    assign rready   = (state_q == ST_R) && rd_ready;
    assign rd_valid = (state_q == ST_R) && rvalid;
    assign rd_data  = rdata;
    assign rd_last  = rlast;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master (DATA_WTH=256, 32 bytes per beat).
// The bench plays the AXI slave and the command/data client. Inputs change 1 ns
// after a rising edge; outputs are sampled 1 ns later, well clear of the edge.
module tb_axi_burst_master;
    import axi_mst_pkg::*;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int IW = 4;

    logic            clk_i, rst_i;
    logic            req_valid, req_ready, req_we;
    logic [AW-1:0]   req_addr;
    logic [7:0]      req_len;
    logic            wd_valid, wd_ready;
    logic [DW-1:0]   wd_data;
    logic [SW-1:0]   wd_strb;
    logic            rd_valid, rd_ready, rd_last;
    logic [DW-1:0]   rd_data;
    logic            done_valid, done_err;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize, awprot, arprot;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic [IW-1:0]   awid, arid, bid, rid;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [3:0]      awcache, awqos, awregion, arcache, arqos, arregion;
    logic            awlock, arlock;
    logic [DW-1:0]   wdata, rdata;
    logic [SW-1:0]   wstrb;
    mst_state_e      dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [DW-1:0] exp_q[$];

    axi_burst_master #(.ADDR_WTH(AW), .DATA_WTH(DW), .ID_WIDTH(IW), .AXI_ID('0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_err(done_err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .awvalid(awvalid), .awready(awready), .awcache(awcache), .awlock(awlock),
        .awprot(awprot), .awqos(awqos), .awregion(awregion),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready), .arcache(arcache), .arlock(arlock),
        .arprot(arprot), .arqos(arqos), .arregion(arregion),
        .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_slave();
        req_valid = 1'b0; arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = '0; rdata = '0;
        bvalid = 1'b0; bresp = 2'b00; bid = '0;
        wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rd_ready = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input logic [15:0] seed, input int beat);
        logic [31:0] w;
        w = {seed, 16'(beat) ^ 16'h5A00};
        return {8{w}};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_slave();
        rst_i = 1'b1; req_we = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b1; rvalid = 1'b1; rd_ready = 1'b1; bvalid = 1'b1;
        #3;
        vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        vec_cnt++; if ({awvalid, wvalid, arvalid, bready, rready, rd_valid, done_valid} !== 7'b0)
            begin err_cnt++; $display("FAIL rst_valids: got %b want 0000000", {awvalid, wvalid, arvalid, bready, rready, rd_valid, done_valid}); end
        vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        cycle(); cycle();
        rst_i = 1'b0;
        clear_slave();
        #1;
        vec_cnt++; if (req_ready !== 1'b1 || done_valid !== 1'b0)
            begin err_cnt++; $display("FAIL post_rst: req_ready=%b done_valid=%b want 1/0", req_ready, done_valid); end
    endtask

    task automatic test_read(input logic [AW-1:0] addr, input logic [7:0] len, input int last_at,
                             input logic [1:0] resp, input int gap, input logic exp_err);
        int beat;
        bit hs;
        logic [DW-1:0] e;
        cycle(); clear_slave();
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len;
        #1;
        vec_cnt++; if (req_ready !== 1'b1 || done_valid !== 1'b0)
            begin err_cnt++; $display("FAIL rd_cmd_accept: req_ready=%b done_valid=%b want 1/0", req_ready, done_valid); end
        cycle(); req_valid = 1'b0;
        hs = 1'b0;
        for (int n = 0; n < 64 && !hs; n++) begin
            if (n > 0) cycle();
            arready = ((n % gap) == gap - 1);
            #1;
            vec_cnt++; if (arvalid !== 1'b1) begin err_cnt++; $display("FAIL ar_valid: got %b want 1 (cycle %0d)", arvalid, n); end
            if (n == 0) begin
                vec_cnt++; if (araddr !== addr || arlen !== len || arsize !== 3'd5 || arburst !== 2'b01 || arid !== 4'd0)
                    begin err_cnt++; $display("FAIL ar_fields: addr=%h len=%0d size=%0d burst=%b id=%0d want %h/%0d/5/01/0", araddr, arlen, arsize, arburst, arid, addr, len); end
            end
            hs = arready;
        end
        if (!hs) begin vec_cnt++; err_cnt++; $display("FAIL ar_timeout: no AR handshake"); end
        exp_q.delete();
        for (int b = 0; b <= last_at; b++) exp_q.push_back(pat(addr[15:0], b));
        beat = 0; hs = 1'b0;
        for (int n = 0; n < 256 && !hs; n++) begin
            cycle();
            arready = 1'b0; rd_ready = 1'b1;
            rvalid = ((n % gap) == gap - 1);
            rdata = pat(addr[15:0], beat); rlast = (beat == last_at); rresp = resp; rid = '0;
            #1;
            vec_cnt++; if (rready !== 1'b1) begin err_cnt++; $display("FAIL r_ready: got %b want 1", rready); end
            if (rvalid) begin
                e = exp_q.pop_front();
                vec_cnt++; if (rd_valid !== 1'b1 || rd_data !== e)
                    begin err_cnt++; $display("FAIL rd_beat%0d: valid=%b data=%h want 1/%h", beat, rd_valid, rd_data, e); end
                vec_cnt++; if (rd_last !== (beat == last_at))
                    begin err_cnt++; $display("FAIL rd_last%0d: got %b want %b", beat, rd_last, beat == last_at); end
                if (beat == last_at) begin
                    vec_cnt++; if (done_valid !== 1'b1 || done_err !== exp_err)
                        begin err_cnt++; $display("FAIL rd_done: valid=%b err=%b want 1/%b", done_valid, done_err, exp_err); end
                    hs = 1'b1;
                end else begin
                    vec_cnt++; if (done_valid !== 1'b0) begin err_cnt++; $display("FAIL rd_early_done: got %b want 0 (beat %0d)", done_valid, beat); end
                end
                beat++;
            end else begin
                vec_cnt++; if (rd_valid !== 1'b0 || done_valid !== 1'b0)
                    begin err_cnt++; $display("FAIL rd_idle: valid=%b done=%b want 0/0", rd_valid, done_valid); end
            end
        end
        if (!hs) begin vec_cnt++; err_cnt++; $display("FAIL r_timeout: burst did not complete"); end
    endtask

    task automatic test_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] resp,
                              input int wgap, input int abort_beat, input logic exp_err);
        int beat;
        bit hs;
        cycle(); clear_slave();
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = len;
        #1;
        vec_cnt++; if (req_ready !== 1'b1 || done_valid !== 1'b0)
            begin err_cnt++; $display("FAIL wr_cmd_accept: req_ready=%b done_valid=%b want 1/0", req_ready, done_valid); end
        hs = 1'b0;
        for (int n = 0; n < 16 && !hs; n++) begin
            cycle();
            req_valid = 1'b0; wd_valid = 1'b1; wd_data = pat(addr[15:0], 0); wready = 1'b1;
            awready = (n == 2);
            #1;
            vec_cnt++; if (awvalid !== 1'b1 || wvalid !== 1'b0)
                begin err_cnt++; $display("FAIL aw_phase: awvalid=%b wvalid=%b want 1/0", awvalid, wvalid); end
            if (n == 0) begin
                vec_cnt++; if (awaddr !== addr || awlen !== len || awsize !== 3'd5 || awburst !== 2'b01 || awid !== 4'd0)
                    begin err_cnt++; $display("FAIL aw_fields: addr=%h len=%0d size=%0d burst=%b id=%0d want %h/%0d/5/01/0", awaddr, awlen, awsize, awburst, awid, addr, len); end
            end
            hs = awready;
        end
        if (!hs) begin vec_cnt++; err_cnt++; $display("FAIL aw_timeout: no AW handshake"); end
        beat = 0; hs = 1'b0;
        for (int n = 0; n < 512 && !hs; n++) begin
            cycle();
            awready = 1'b0; wready = 1'b1;
            wd_valid = ((n % (wgap + 1)) == 0);
            wd_data = pat(addr[15:0], beat); wd_strb = '1;
            if (wd_valid && beat == abort_beat) begin
                rst_i = 1'b1;
                #1;
                vec_cnt++; if (wvalid !== 1'b0 || done_valid !== 1'b0 || dbg_state !== ST_IDLE)
                    begin err_cnt++; $display("FAIL abort: wvalid=%b done=%b state=%0d want 0/0/0", wvalid, done_valid, dbg_state); end
                return;
            end
            #1;
            vec_cnt++; if (wvalid !== wd_valid || wd_ready !== 1'b1)
                begin err_cnt++; $display("FAIL w_follow: wvalid=%b wd_ready=%b want %b/1", wvalid, wd_ready, wd_valid); end
            if (wd_valid) begin
                vec_cnt++; if (wdata !== pat(addr[15:0], beat) || wstrb !== {SW{1'b1}})
                    begin err_cnt++; $display("FAIL w_data%0d: data=%h strb=%h", beat, wdata, wstrb); end
                vec_cnt++; if (wlast !== (beat == len))
                    begin err_cnt++; $display("FAIL wlast%0d: got %b want %b", beat, wlast, beat == len); end
                if (beat == len) hs = 1'b1;
                beat++;
            end
        end
        if (!hs) begin vec_cnt++; err_cnt++; $display("FAIL w_timeout: burst did not complete"); end
        hs = 1'b0;
        for (int n = 0; n < 16 && !hs; n++) begin
            cycle();
            wd_valid = 1'b1; wready = 1'b1;
            bvalid = (n == 2); bresp = resp; bid = '0;
            #1;
            vec_cnt++; if (wvalid !== 1'b0 || bready !== 1'b1)
                begin err_cnt++; $display("FAIL b_phase: wvalid=%b bready=%b want 0/1", wvalid, bready); end
            if (bvalid) begin
                vec_cnt++; if (done_valid !== 1'b1 || done_err !== exp_err)
                    begin err_cnt++; $display("FAIL wr_done: valid=%b err=%b want 1/%b", done_valid, done_err, exp_err); end
                hs = 1'b1;
            end else begin
                vec_cnt++; if (done_valid !== 1'b0) begin err_cnt++; $display("FAIL wr_early_done: got %b want 0", done_valid); end
            end
        end
        if (!hs) begin vec_cnt++; err_cnt++; $display("FAIL b_timeout: no B handshake"); end
    endtask

    task automatic test_reject(input logic [AW-1:0] addr, input logic [7:0] len, input logic we);
        cycle(); clear_slave();
        req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len;
        #1;
        vec_cnt++; if (req_ready !== 1'b1 || done_valid !== 1'b0)
            begin err_cnt++; $display("FAIL rej_cmd: req_ready=%b done=%b want 1/0", req_ready, done_valid); end
        cycle(); req_valid = 1'b0; arready = 1'b1; awready = 1'b1;
        #1;
        vec_cnt++; if (done_valid !== 1'b1 || done_err !== 1'b1)
            begin err_cnt++; $display("FAIL rej_done: valid=%b err=%b want 1/1", done_valid, done_err); end
        vec_cnt++; if (arvalid !== 1'b0 || awvalid !== 1'b0 || dbg_state !== ST_IDLE || req_ready !== 1'b1)
            begin err_cnt++; $display("FAIL rej_traffic: arvalid=%b awvalid=%b state=%0d ready=%b want 0/0/0/1", arvalid, awvalid, dbg_state, req_ready); end
        cycle();
        #1;
        vec_cnt++; if (done_valid !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0)
            begin err_cnt++; $display("FAIL rej_after: done=%b arvalid=%b awvalid=%b want 0/0/0", done_valid, arvalid, awvalid); end
    endtask

    task automatic test_back_to_back();
        // SLVERR on B, then a read issued in the cycle right after the done pulse;
        // the read sits exactly at the end of a 4 KiB page and is a single beat.
        test_write(32'h8000_0200, 8'd1, 2'b10, 0, -1, 1'b1);
        test_read(32'h8000_0FE0, 8'd0, 0, 2'b00, 1, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        test_write(32'h8000_0600, 8'd5, 2'b00, 0, 2, 1'b0);
        cycle();
        rst_i = 1'b0;
        clear_slave();
        arready = 1'b1; awready = 1'b1; wready = 1'b1; wd_valid = 1'b1;
        bvalid = 1'b1; rvalid = 1'b1; rlast = 1'b1; rd_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            vec_cnt++; if ({awvalid, wvalid, arvalid, bready, rready, rd_valid, done_valid} !== 7'b0)
                begin err_cnt++; $display("FAIL post_abort_quiet: got %b want 0000000", {awvalid, wvalid, arvalid, bready, rready, rd_valid, done_valid}); end
            cycle();
        end
        test_read(32'h8000_0700, 8'd2, 2, 2'b00, 1, 1'b0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_read(32'h8000_0000, 8'd3, 3, 2'b00, 4, 1'b0);      // 1-in-4 slave
        test_write(32'h8000_0100, 8'd7, 2'b00, 0, -1, 1'b0);
        test_reject(32'h8000_0FE0, 8'd1, 1'b0);                  // 4 KiB crossing
        test_reject(32'h8000_0104, 8'd0, 1'b1);                  // misaligned
        test_back_to_back();
        test_write(32'h8000_0300, 8'd3, 2'b00, 2, -1, 1'b0);    // wd_valid gaps
        test_read(32'h8000_0400, 8'd3, 1, 2'b00, 1, 1'b1);      // early rlast
        test_read(32'h8000_0400, 8'd1, 2, 2'b00, 1, 1'b1);      // rlast late
        test_read(32'h8000_0500, 8'd1, 1, 2'b10, 2, 1'b1);      // SLVERR on R
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
